// File: rtl/ctrlu_pkg.sv
// ctrlu_pkg: shared constants and types for the RV32I control unit.
// Holds opcode constants, the ALU operation encoding, write-back and
// byte-mask constants, and the decoded-control bundle type.
package ctrlu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_OR     = 4'b0101,
    ALU_AND    = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASS_B = 4'b1111
  } alu_op_e;

  localparam logic [1:0] WB_PC4  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b10;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef struct packed {
    logic       pc_sel;
    logic       rd_wren;
    logic       insn_vld;
    logic       br_un;
    logic       opa_sel;
    logic       opb_sel;
    alu_op_e    alu_op;
    logic       mem_wren;
    logic [3:0] mask;
    logic       mem_un;
    logic [1:0] wb_sel;
  } ctrl_t;

  // Access size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 none.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return MASK_BYTE;
      2'b01:   return MASK_HALF;
      2'b10:   return MASK_WORD;
      default: return MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctrlu_if.sv
// ctrlu_if: instruction/comparator inputs and control outputs of ctrlu.
// master: drives i_instr/i_br_less/i_br_equal, observes o_* controls.
// slave:  the control unit itself.
interface ctrlu_if;
  logic [31:0] i_instr;
  logic        i_br_less;
  logic        i_br_equal;
  logic        o_pc_sel;
  logic        o_pc_wren;
  logic        o_rd_wren;
  logic        o_insn_vld;
  logic        o_br_un;
  logic        o_opa_sel;
  logic        o_opb_sel;
  logic [3:0]  o_alu_op;
  logic        o_mem_wren;
  logic [3:0]  o_mask;
  logic        o_mem_un;
  logic [1:0]  o_wb_sel;

  modport master (
    output i_instr, i_br_less, i_br_equal,
    input  o_pc_sel, o_pc_wren, o_rd_wren, o_insn_vld, o_br_un, o_opa_sel,
           o_opb_sel, o_alu_op, o_mem_wren, o_mask, o_mem_un, o_wb_sel
  );

  modport slave (
    input  i_instr, i_br_less, i_br_equal,
    output o_pc_sel, o_pc_wren, o_rd_wren, o_insn_vld, o_br_un, o_opa_sel,
           o_opb_sel, o_alu_op, o_mem_wren, o_mask, o_mem_un, o_wb_sel
  );
endinterface

// File: rtl/ctrlu_dec.sv
// ctrlu_dec: purely combinational RV32I decode into a ctrl_t bundle.
// Ports: instr/br_less/br_equal in, ctrl out. Zero latency.
// Any malformed encoding collapses to the fixed "invalid" bundle.
module ctrlu_dec
  import ctrlu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        br_less,
  input  logic        br_equal,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;
  ctrl_t      d;
  logic       ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    d        = '0;
    d.alu_op = ALU_ADD;
    d.wb_sel = WB_PC4;
    ok       = 1'b1;

    case (opc)
      OPC_LUI: begin
        d.rd_wren = 1'b1; d.opb_sel = 1'b1;
        d.alu_op  = ALU_PASS_B; d.wb_sel = WB_ALU;
      end
      OPC_AUIPC: begin
        d.rd_wren = 1'b1; d.opa_sel = 1'b1; d.opb_sel = 1'b1;
        d.wb_sel  = WB_ALU;
      end
      OPC_JAL: begin
        d.rd_wren = 1'b1; d.opa_sel = 1'b1; d.opb_sel = 1'b1;
        d.pc_sel  = 1'b1;
      end
      OPC_JALR: begin
        d.rd_wren = 1'b1; d.opb_sel = 1'b1; d.pc_sel = 1'b1;
        ok        = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.opa_sel = 1'b1; d.opb_sel = 1'b1;
        d.br_un   = (f3[2:1] == 2'b11);
        // f3[0] inverts the sense: BNE/BGE/BGEU are the negated forms.
        d.pc_sel  = (f3[2] ? br_less : br_equal) ^ f3[0];
        ok        = (f3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        d.rd_wren = 1'b1; d.opb_sel = 1'b1; d.wb_sel = WB_LOAD;
        d.mask    = size_mask(f3[1:0]);
        d.mem_un  = f3[2];
        ok        = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        d.mem_wren = 1'b1; d.opb_sel = 1'b1;
        d.mask     = size_mask(f3[1:0]);
        ok         = (f3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_OPIMM, OPC_OP: begin
        d.rd_wren = 1'b1;
        d.opb_sel = (opc == OPC_OPIMM);
        d.wb_sel  = WB_ALU;
        case (f3)
          3'b000:  d.alu_op = ALU_ADD;
          3'b001:  d.alu_op = ALU_SLL;
          3'b010:  d.alu_op = ALU_SLT;
          3'b011:  d.alu_op = ALU_SLTU;
          3'b100:  d.alu_op = ALU_XOR;
          3'b101:  d.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  d.alu_op = ALU_OR;
          default: d.alu_op = ALU_AND;
        endcase
        if (opc == OPC_OP) begin
          if (f7 == F7_ALT) begin
            ok = (f3 == 3'b101) || (f3 == 3'b000);
            if (f3 == 3'b000) d.alu_op = ALU_SUB;
          end else begin
            ok = (f7 == F7_BASE);
          end
        end else if (f3 == 3'b001) begin
          ok = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      end
      default: ok = 1'b0;
    endcase

    d.insn_vld = 1'b1;
    if (!ok) begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      ctrl.wb_sel = WB_ALU;
    end else begin
      ctrl = d;
    end
  end

endmodule

// File: rtl/ctrlu.sv
// ctrlu: RV32I control unit top; decode plus run/reset gating.
// Ports: i_clk, i_rst_n (sync, active-low), bus (ctrlu_if.slave).
// Outputs are combinational from bus inputs; run_q masks side effects.
module ctrlu
  import ctrlu_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  ctrlu_if.slave bus
);

  ctrl_t ctrl;
  logic  run_q;

  ctrlu_dec u_dec (
    .instr    (bus.i_instr),
    .br_less  (bus.i_br_less),
    .br_equal (bus.i_br_equal),
    .ctrl     (ctrl)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Anything with architectural side effects is held off until run_q.
  assign bus.o_pc_wren  = run_q;
  assign bus.o_pc_sel   = run_q & ctrl.pc_sel;
  assign bus.o_rd_wren  = run_q & ctrl.rd_wren;
  assign bus.o_mem_wren = run_q & ctrl.mem_wren;
  assign bus.o_insn_vld = run_q & ctrl.insn_vld;

  assign bus.o_br_un    = ctrl.br_un;
  assign bus.o_opa_sel  = ctrl.opa_sel;
  assign bus.o_opb_sel  = ctrl.opb_sel;
  assign bus.o_alu_op   = ctrl.alu_op;
  assign bus.o_mask     = ctrl.mask;
  assign bus.o_mem_un   = ctrl.mem_un;
  assign bus.o_wb_sel   = ctrl.wb_sel;

endmodule

// File: tb/tb_ctrlu.sv
// tb_ctrlu: scoreboard bench for ctrlu.
// Stimulus pushes expected control words from an instruction-level model;
// a monitor pops and compares once per cycle on the falling edge.
module tb_ctrlu;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  ctrlu_if bus ();

  ctrlu dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // {pc_sel,pc_wren,rd_wren,insn_vld,br_un,opa,opb,alu[3:0],mem_wren,mask[3:0],mem_un,wb[1:0]}
  typedef struct {
    logic [18:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Instruction-level reference: classify the mnemonic, then fill fields.
  function automatic logic [18:0] model(input logic [31:0] ins, input logic less,
                                        input logic eq, input logic run);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic vld, rd, jmp, mw, bun, opa, opb, mun;
    logic [3:0] alu, mask;
    logic [1:0] wb;
    logic [3:0] size_tab [3];
    logic [3:0] imm_alu [8];
    size_tab = '{4'b0001, 4'b0011, 4'b1111};
    imm_alu  = '{4'h0, 4'h7, 4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'h6};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    vld = 0; rd = 0; jmp = 0; mw = 0; bun = 0; opa = 0; opb = 0; mun = 0;
    alu = 4'h0; mask = 4'h0; wb = 2'b00;
    case (opc)
      7'h37: begin vld = 1; rd = 1; opb = 1; alu = 4'hF; wb = 2'b01; end
      7'h17: begin vld = 1; rd = 1; opa = 1; opb = 1; wb = 2'b01; end
      7'h6F: begin vld = 1; rd = 1; opa = 1; opb = 1; jmp = 1; end
      7'h67: begin vld = (f3 == 0); rd = 1; opb = 1; jmp = 1; end
      7'h63: begin
        opa = 1; opb = 1;
        case (f3)
          0: begin vld = 1; jmp = eq; end
          1: begin vld = 1; jmp = !eq; end
          4: begin vld = 1; jmp = less; end
          5: begin vld = 1; jmp = !less; end
          6: begin vld = 1; jmp = less; bun = 1; end
          7: begin vld = 1; jmp = !less; bun = 1; end
          default: vld = 0;
        endcase
      end
      7'h03: begin
        rd = 1; opb = 1; wb = 2'b10;
        if (f3 == 0 || f3 == 1 || f3 == 2) begin vld = 1; mask = size_tab[f3]; end
        if (f3 == 4 || f3 == 5) begin vld = 1; mask = size_tab[f3 - 4]; mun = 1; end
      end
      7'h23: begin
        mw = 1; opb = 1;
        if (f3 <= 2) begin vld = 1; mask = size_tab[f3]; end
      end
      7'h13: begin
        rd = 1; opb = 1; wb = 2'b01; alu = imm_alu[f3]; vld = 1;
        if (f3 == 1 && f7 != 0) vld = 0;
        if (f3 == 5) begin
          if (f7 == 7'h20) alu = 4'h9;
          else if (f7 != 0) vld = 0;
        end
      end
      7'h33: begin
        rd = 1; wb = 2'b01; alu = imm_alu[f3];
        if (f7 == 0) vld = 1;
        else if (f7 == 7'h20 && f3 == 0) begin vld = 1; alu = 4'h1; end
        else if (f7 == 7'h20 && f3 == 5) begin vld = 1; alu = 4'h9; end
      end
      default: vld = 0;
    endcase
    if (!vld) begin
      rd = 0; jmp = 0; mw = 0; bun = 0; opa = 0; opb = 0; mun = 0;
      alu = 4'h0; mask = 4'h0; wb = 2'b01;
    end
    if (!run) begin rd = 0; mw = 0; vld = 0; jmp = 0; end
    return {jmp, run, rd, vld, bun, opa, opb, alu, mw, mask, mun, wb};
  endfunction

  // One cycle: the coming edge samples the current i_rst_n, then new inputs go on.
  task automatic step(input logic [31:0] ins, input logic less, input logic eq,
                      input logic rstn, input string name);
    item_t it;
    logic  run;
    @(posedge i_clk);
    run = i_rst_n;
    #1;
    bus.i_instr    = ins;
    bus.i_br_less  = less;
    bus.i_br_equal = eq;
    i_rst_n        = rstn;
    it.exp  = model(ins, less, eq, run);
    it.name = name;
    sb_q.push_back(it);
  endtask

  // Monitor: one comparison per queued expectation, away from the rising edge.
  initial begin
    item_t       it;
    logic [18:0] act;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {bus.o_pc_sel, bus.o_pc_wren, bus.o_rd_wren, bus.o_insn_vld, bus.o_br_un,
               bus.o_opa_sel, bus.o_opb_sel, bus.o_alu_op, bus.o_mem_wren, bus.o_mask,
               bus.o_mem_un, bus.o_wb_sel};
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s instr=%08h got=%019b want=%019b", it.name, bus.i_instr,
                   act, it.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs [11];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    case ($urandom_range(0, 11))
      11:      ;
      default: r[6:0] = opcs[$urandom_range(0, 10)];
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h00;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    int guard;
    bus.i_instr    = 32'h00032283;
    bus.i_br_less  = 1'b0;
    bus.i_br_equal = 1'b0;
    i_rst_n        = 1'b0;

    step(32'h00032283, 0, 0, 0, "reset_lw_0");
    step(32'h00032283, 0, 0, 0, "reset_lw_1");
    step(32'h00032283, 0, 0, 1, "release_lw");
    step(32'h00032283, 0, 0, 1, "run_lw");
    step(32'h00532223, 0, 0, 1, "sw");
    step(32'h007302B3, 0, 0, 1, "add");
    step(32'h00628263, 0, 1, 1, "beq_taken");
    step(32'h00628263, 1, 0, 1, "beq_not_taken");
    step(32'h100002B7, 0, 0, 1, "lui");
    step(32'h064000EF, 0, 0, 1, "jal");
    step(32'h00231293, 0, 0, 1, "slli");
    step(32'h007342B3, 0, 0, 1, "xor");
    step(32'h00000000, 0, 0, 1, "zero_word");
    step(32'h0000000F, 0, 0, 1, "fence");
    step(32'h40A35293, 0, 0, 1, "srai");
    step(32'h0062E263, 1, 0, 1, "bltu_taken");
    step(32'h0062A263, 1, 1, 1, "blt_f3_010");
    step(32'h00532223, 0, 0, 0, "sw_reset_asserted");
    step(32'h00532223, 0, 0, 1, "sw_in_reset");
    step(32'h064000EF, 0, 0, 1, "jal_after_reset");

    for (int i = 0; i < 400; i++) begin
      step(rand_instr(), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 24) != 0), "random");
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge i_clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrlu.md
CTRLU -- requirements
Module: ctrlu

Interface
- REQ-001 No parameters.
- REQ-002 One clock; reset is synchronous and active-low.
- REQ-003 i_clk  input  1  rising-edge clock.
- REQ-004 i_rst_n  input  1  synchronous active-low reset.
- REQ-005 i_instr  input  32  RV32I instruction word of the current cycle.
- REQ-006 i_br_less  input  1  branch comparator: rs1 < rs2 (signedness per o_br_un).
- REQ-007 i_br_equal  input  1  branch comparator: rs1 == rs2.
- REQ-008 o_pc_sel  output  1  0 = PC+4, 1 = ALU result (jump/taken branch).
- REQ-009 o_pc_wren  output  1  PC register write enable.
- REQ-010 o_rd_wren  output  1  register-file write enable.
- REQ-011 o_insn_vld  output  1  instruction is a supported, well-formed RV32I opcode.
- REQ-012 o_br_un  output  1  1 = unsigned compare (BLTU/BGEU).
- REQ-013 o_opa_sel  output  1  ALU A: 0 = rs1, 1 = PC.
- REQ-014 o_opb_sel  output  1  ALU B: 0 = rs2, 1 = immediate.
- REQ-015 o_alu_op  output  4  ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001, PASS_B 1111.
- REQ-016 o_mem_wren  output  1  data-memory write enable.
- REQ-017 o_mask  output  4  byte enables: byte 0001, half 0011, word 1111; 0000 for non-memory instructions.
- REQ-018 o_mem_un  output  1  1 = zero-extend load (LBU/LHU).
- REQ-019 o_wb_sel  output  2  write-back source: 00 PC+4, 01 ALU, 10 load data, 11 unused.

Function
- REQ-020 Decode SHALL be purely combinational from i_instr, i_br_less and i_br_equal; zero-cycle latency, gated only by internal flag run_q.
- REQ-021 run_q SHALL be 0 while i_rst_n is low at a clock edge and 1 from the first rising edge sampling i_rst_n high.
- REQ-022 While run_q = 0: o_pc_wren, o_rd_wren, o_mem_wren, o_insn_vld and o_pc_sel SHALL be 0; other outputs follow decode.
- REQ-023 With run_q = 1, o_pc_wren SHALL be 1 every cycle.
- REQ-024 LUI (0110111): rd_wren 1, opb 1, alu PASS_B, wb 01.
- REQ-025 AUIPC (0010111): rd_wren 1, opa 1, opb 1, alu ADD, wb 01.
- REQ-026 JAL (1101111): rd_wren 1, opa 1, opb 1, alu ADD, pc_sel 1, wb 00.
- REQ-027 JALR (1100111, funct3 000): rd_wren 1, opa 0, opb 1, alu ADD, pc_sel 1, wb 00.
- REQ-028 Branch (1100011): opa 1, opb 1, alu ADD, rd_wren 0; pc_sel = BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less; br_un 1 only for funct3 110/111; funct3 010/011 invalid.
- REQ-029 Load (0000011): rd_wren 1, opb 1, alu ADD, wb 10; LB/LBU mask 0001, LH/LHU 0011, LW 1111; mem_un 1 for 100/101; other funct3 invalid.
- REQ-030 Store (0100011): mem_wren 1, rd_wren 0, opb 1, alu ADD; SB/SH/SW masks as loads; other funct3 invalid.
- REQ-031 OP-IMM (0010011): rd_wren 1, opb 1, wb 01; alu from funct3 (SUB not selectable); SLLI needs funct7 0000000, SRLI/SRAI funct7 0000000/0100000, else invalid.
- REQ-032 OP (0110011): rd_wren 1, opb 0, wb 01; funct7 0100000 only for SUB/SRA, else 0000000 required, otherwise invalid.
- REQ-033 Any other opcode, instr[1:0] != 11, or invalid funct field: insn_vld 0, rd_wren 0, mem_wren 0, pc_sel 0, mask 0000, alu ADD, wb 01, remaining selects 0; o_pc_wren stays 1.
- REQ-034 Default for unlisted outputs in each class SHALL be 0 (br_un 0, mem_un 0, mask 0000).

Reset
- REQ-035 Reset SHALL be sampled only on rising i_clk; output gating per REQ-022 applies from the same edge.
- REQ-036 Reset mid-operation SHALL suppress all write enables from the next edge regardless of i_instr.

Structure
- REQ-037 Shared package ctrlu_pkg SHALL hold opcode constants, the alu_op enum, wb_sel and mask constants.
- REQ-038 One sub-module, ctrlu_dec, holds combinational decode; ctrlu holds run_q and the gating.

Verification
- REQ-039 Reset held low 2 cycles, i_instr 00032283 -> pc_wren 0, rd_wren 0, insn_vld 0; first edge after release -> pc_wren 1.
- REQ-040 00032283 (lw) -> rd_wren 1, opb 1, alu 0000, mask 1111, wb 10, mem_wren 0, insn_vld 1.
- REQ-041 00532223 (sw) -> mem_wren 1, rd_wren 0, mask 1111; 007302B3 (add) -> opb 0, alu 0000, wb 01.
- REQ-042 00628263 (beq) eq=1 -> pc_sel 1, opa 1, opb 1; eq=0 -> pc_sel 0; rd_wren 0 both.
- REQ-043 100002B7 (lui) -> alu 1111, wb 01; 064000EF (jal) -> pc_sel 1, wb 00, rd_wren 1; 00231293 (slli) -> alu 0111; 007342B3 (xor) -> alu 0100.
- REQ-044 00000000 and 0000000F -> insn_vld 0, rd_wren 0, mem_wren 0, pc_wren 1.
